imem_responder: RTL and testbench

Instruction-side memory responder serving the pipelined MIPS core's fetch port (`instr_addr`/`instr_in`/`instr_stall`/`instr_clear`) from the memory end. It owns the program store, accepts a program image over a valid/ready load port while holding the core, and then answers fetches combinationally. It injects NOPs for taken-branch squash slots and records the first misaligned or out-of-range fetch.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/imem_responder_if.sv | 31 +++
 rtl/imem_array.sv | 20 ++
 rtl/imem_responder.sv | 96 +++++++++
 tb/tb_imem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct fields, the canonical NOP and the
// instruction-memory responder state type.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch port toward the core plus the program-image load port and status.
interface imem_responder_if #(
    parameter int AW = 10
);
    logic [31:0]   instr_addr;
    logic [31:0]   instr_data;
    logic          instr_stall;
    logic          instr_clear;
    logic          load_start;
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_last;
    logic          cpu_hold;
    logic          fetch_fault;
    logic [31:0]   fault_addr;
    logic [31:0]   fetch_count;

    modport master (
        output instr_addr, instr_stall, instr_clear,
        output load_start, load_valid, load_addr, load_data, load_last,
        input  instr_data, load_ready, cpu_hold, fetch_fault, fault_addr, fetch_count
    );

    modport slave (
        input  instr_addr, instr_stall, instr_clear,
        input  load_start, load_valid, load_addr, load_data, load_last,
        output instr_data, load_ready, cpu_hold, fetch_fault, fault_addr, fetch_count
    );
endinterface

// File: rtl/imem_array.sv
// Program store: one synchronous write port, one asynchronous read port.
module imem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_responder.sv
// Instruction-side responder: loads a program image while holding the core,
// then serves fetches combinationally with squash-slot NOPs and fault capture.
module imem_responder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned SQUASH_EXTRA = 1,
    parameter logic [31:0] NOP_WORD     = mips_pkg::NOP_WORD
) (
    input logic             clk,
    input logic             reset,
    imem_responder_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int SW = (SQUASH_EXTRA > 0) ? $clog2(SQUASH_EXTRA + 1) : 1;
    localparam logic [SW-1:0] SQ_LOAD = SW'(SQUASH_EXTRA);

    imem_state_t   state_q, state_d;
    logic [SW-1:0] squash_q, squash_d;
    logic          fault_q, fault_d;
    logic [31:0]   faddr_q, faddr_d;
    logic [31:0]   count_q, count_d;

    logic [31:0] off;
    logic [31:0] rdata;
    logic        is_run, fault, forced, we;

    // Modular subtract; below-base addresses are caught by the explicit compare.
    assign off    = bus.instr_addr - BASE_ADDR;
    assign fault  = (bus.instr_addr[1:0] != 2'b00) || (bus.instr_addr < BASE_ADDR) ||
                    ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
    assign is_run = (state_q == ST_RUN);
    assign forced = !is_run || fault || bus.instr_clear || (squash_q != '0);
    assign we     = !is_run && bus.load_valid && !reset;

    imem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (off[AW+1:2]),
        .rdata (rdata)
    );

    assign bus.instr_data  = forced ? NOP_WORD : rdata;
    assign bus.load_ready  = !is_run;
    assign bus.cpu_hold    = !is_run;
    assign bus.fetch_fault = fault_q;
    assign bus.fault_addr  = faddr_q;
    assign bus.fetch_count = count_q;

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        fault_d  = fault_q;
        faddr_d  = faddr_q;
        count_d  = count_q;
        if (!is_run) begin
            if (bus.load_valid && bus.load_last) state_d = ST_RUN;
        end else if (bus.load_start) begin
            // Reload wins over a same-cycle clear, so no squash survives it.
            state_d  = ST_LOAD;
            squash_d = '0;
            fault_d  = 1'b0;
            faddr_d  = '0;
            count_d  = '0;
        end else begin
            if (bus.instr_clear)
                squash_d = SQ_LOAD;
            else if ((squash_q != '0) && !bus.instr_stall)
                squash_d = squash_q - SW'(1);
            if (fault && !fault_q) begin
                fault_d = 1'b1;
                faddr_d = bus.instr_addr;
            end
            if (!forced && !bus.instr_stall) count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            squash_q <= '0;
            fault_q  <= 1'b0;
            faddr_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            fault_q  <= fault_d;
            faddr_q  <= faddr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed vector table, hand sequences for the
// load/reset/reload corners, then random traffic against a behavioural model.
module tb_imem_responder;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          SQ    = 1;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_responder_if #(.AW(AW)) bus ();

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .SQUASH_EXTRA(SQ),
        .NOP_WORD    (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model
    bit          m_run = 1'b0;
    int          m_sq  = 0;
    bit          m_flt = 1'b0;
    logic [31:0] m_faddr = '0;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_bad(input logic [31:0] a);
        if (a % 4 != 0) return 1'b1;
        if (a < BASE) return 1'b1;
        return ((a - BASE) / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] m_data();
        if (!m_run || m_bad(bus.instr_addr) || bus.instr_clear || m_sq != 0) return NOP;
        return m_mem[(bus.instr_addr - BASE) / 4];
    endfunction

    task automatic drive(input logic rst, input logic [31:0] addr, input logic clr, input logic stl,
                         input logic ls, input logic lv, input logic [AW-1:0] la,
                         input logic [31:0] ld, input logic ll);
        reset           = rst;
        bus.instr_addr  = addr;
        bus.instr_clear = clr;
        bus.instr_stall = stl;
        bus.load_start  = ls;
        bus.load_valid  = lv;
        bus.load_addr   = la;
        bus.load_data   = ld;
        bus.load_last   = ll;
    endtask

    task automatic check_model();
        chk("instr_data",  bus.instr_data, m_data());
        chk("load_ready",  32'(bus.load_ready), 32'(!m_run));
        chk("cpu_hold",    32'(bus.cpu_hold), 32'(!m_run));
        chk("fetch_fault", 32'(bus.fetch_fault), 32'(m_flt));
        chk("fault_addr",  bus.fault_addr, m_faddr);
        chk("fetch_count", bus.fetch_count, m_cnt);
    endtask

    // Advance the model with this cycle's inputs, then take the clock edge.
    task automatic tick();
        bit bad, forced;
        bad    = m_bad(bus.instr_addr);
        forced = !m_run || bad || bus.instr_clear || m_sq != 0;
        if (reset) begin
            m_run = 0; m_sq = 0; m_flt = 0; m_faddr = '0; m_cnt = '0;
        end else if (!m_run) begin
            if (bus.load_valid) begin
                m_mem[bus.load_addr] = bus.load_data;
                if (bus.load_last) m_run = 1;
            end
        end else if (bus.load_start) begin
            m_run = 0; m_sq = 0; m_flt = 0; m_faddr = '0; m_cnt = '0;
        end else begin
            if (bus.instr_clear) m_sq = SQ;
            else if (m_sq > 0 && !bus.instr_stall) m_sq--;
            if (bad && !m_flt) begin
                m_flt   = 1;
                m_faddr = bus.instr_addr;
            end
            if (!forced && !bus.instr_stall) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic rst, input logic [31:0] addr, input logic clr, input logic stl,
                       input logic ls, input logic lv, input logic [AW-1:0] la,
                       input logic [31:0] ld, input logic ll);
        drive(rst, addr, clr, stl, ls, lv, la, ld, ll);
        #3;
        check_model();
        tick();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        clr;
        logic        stl;
        logic [31:0] exp_data;
        logic        exp_flt;
        logic [31:0] exp_faddr;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Expected values are those seen during the cycle, before its edge.
        vecs[0]  = '{BASE + 8,         1'b0, 1'b0, 32'h01095021, 1'b0, 32'h0,    32'd0};
        vecs[1]  = '{BASE + 0,         1'b1, 1'b0, NOP,          1'b0, 32'h0,    32'd1};
        vecs[2]  = '{BASE + 4,         1'b0, 1'b0, NOP,          1'b0, 32'h0,    32'd1};
        vecs[3]  = '{BASE + 4,         1'b0, 1'b0, 32'h24090003, 1'b0, 32'h0,    32'd1};
        vecs[4]  = '{BASE + 0,         1'b1, 1'b0, NOP,          1'b0, 32'h0,    32'd2};
        vecs[5]  = '{BASE + 4,         1'b0, 1'b1, NOP,          1'b0, 32'h0,    32'd2};
        vecs[6]  = '{BASE + 4,         1'b0, 1'b0, NOP,          1'b0, 32'h0,    32'd2};
        vecs[7]  = '{BASE + 4,         1'b0, 1'b0, 32'h24090003, 1'b0, 32'h0,    32'd2};
        vecs[8]  = '{BASE + 12,        1'b0, 1'b1, 32'h08000000, 1'b0, 32'h0,    32'd3};
        vecs[9]  = '{BASE + 6,         1'b0, 1'b0, NOP,          1'b0, 32'h0,    32'd3};
        vecs[10] = '{BASE + 4 * DEPTH, 1'b0, 1'b0, NOP,          1'b1, BASE + 6, 32'd3};
        vecs[11] = '{BASE - 4,         1'b0, 1'b0, NOP,          1'b1, BASE + 6, 32'd3};
        vecs[12] = '{BASE + 0,         1'b0, 1'b0, 32'h24080005, 1'b1, BASE + 6, 32'd3};

        // Reset and reset state
        cyc(1'b1, BASE, 0, 0, 0, 0, '0, '0, 0);
        drive(1'b0, BASE, 0, 0, 0, 0, '0, '0, 0);
        #3;
        chk("rst load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("rst instr_data", bus.instr_data, NOP);
        chk("rst fetch_fault", 32'(bus.fetch_fault), 32'd0);
        chk("rst fault_addr", bus.fault_addr, 32'd0);
        chk("rst fetch_count", bus.fetch_count, 32'd0);
        check_model();
        tick();

        // Two beats, reset mid-load, then finish the image
        cyc(1'b0, BASE, 0, 0, 0, 1, 4'd0, 32'h24080005, 0);
        cyc(1'b0, BASE, 0, 0, 0, 1, 4'd1, 32'h24090003, 0);
        cyc(1'b1, BASE, 0, 0, 0, 0, 4'd0, 32'h0, 0);
        drive(1'b0, BASE, 0, 0, 1, 1, 4'd2, 32'h01095021, 0);
        #3;
        chk("midrst load_ready", 32'(bus.load_ready), 32'd1);
        chk("midrst cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check_model();
        tick();
        drive(1'b0, BASE, 0, 0, 0, 1, 4'd3, 32'h08000000, 1);
        #3;
        chk("last beat cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check_model();
        tick();

        // Directed fetch vectors: squash, stall-held squash, faults, counting
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, vecs[i].addr, vecs[i].clr, vecs[i].stl, 0, 0, '0, '0, 0);
            #3;
            chk($sformatf("vec%0d cpu_hold", i), 32'(bus.cpu_hold), 32'd0);
            chk($sformatf("vec%0d load_ready", i), 32'(bus.load_ready), 32'd0);
            chk($sformatf("vec%0d instr_data", i), bus.instr_data, vecs[i].exp_data);
            chk($sformatf("vec%0d fetch_fault", i), 32'(bus.fetch_fault), 32'(vecs[i].exp_flt));
            chk($sformatf("vec%0d fault_addr", i), bus.fault_addr, vecs[i].exp_faddr);
            chk($sformatf("vec%0d fetch_count", i), bus.fetch_count, vecs[i].exp_cnt);
            check_model();
            tick();
        end

        // load_start with a same-cycle clear; reload word 0
        cyc(1'b0, BASE, 1, 0, 1, 0, '0, '0, 0);
        drive(1'b0, BASE, 0, 0, 0, 0, '0, '0, 0);
        #3;
        chk("reload cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("reload fetch_fault", 32'(bus.fetch_fault), 32'd0);
        chk("reload fault_addr", bus.fault_addr, 32'd0);
        chk("reload fetch_count", bus.fetch_count, 32'd0);
        check_model();
        tick();
        cyc(1'b0, BASE, 0, 0, 0, 1, 4'd0, 32'h2402000A, 1);
        drive(1'b0, BASE, 0, 0, 0, 0, '0, '0, 0);
        #3;
        chk("reload word0", bus.instr_data, 32'h2402000A);
        check_model();
        tick();

        // 10 real fetches, 3 stalled, 2 squashed
        cyc(1'b0, BASE, 0, 0, 1, 0, '0, '0, 0);
        cyc(1'b0, BASE, 0, 0, 0, 1, 4'd0, 32'h2402000A, 1);
        for (int i = 0; i < 10; i++) cyc(1'b0, BASE + 32'(4 * (i % 4)), 0, 0, 0, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, BASE + 4, 0, 1, 0, 0, '0, '0, 0);
        cyc(1'b0, BASE, 1, 0, 0, 0, '0, '0, 0);
        cyc(1'b0, BASE + 8, 0, 0, 0, 0, '0, '0, 0);
        drive(1'b0, BASE, 0, 1, 0, 0, '0, '0, 0);
        #3;
        chk("fetch_count10", bus.fetch_count, 32'd10);
        check_model();
        tick();

        // Full image of random words, then random traffic
        cyc(1'b0, BASE, 0, 0, 1, 0, '0, '0, 0);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, BASE, 0, 0, 0, 1, AW'(i), $urandom, (i == DEPTH - 1));
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic        rst;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            else if (r == 1) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (r == 2) a = BASE - 32'(4 * $urandom_range(1, 4));
            else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            rst = ($urandom_range(0, 399) == 0);
            if (m_run)
                cyc(rst, a, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 59) == 0), rst ? 1'b0 : 1'($urandom),
                    AW'($urandom), $urandom, 1'($urandom));
            else
                cyc(rst, a, 1'($urandom), 1'($urandom), 1'($urandom),
                    rst ? 1'b0 : ($urandom_range(0, 3) != 0), AW'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
